pipe_stage_reg: RTL and testbench

- Parametrised, reusable Y86 inter-stage pipeline register, replacing the hand-written per-stage registers.
- Instantiated at the D->E boundary first; later reused at F/D, E/M and M/W with unused fields tied off.
- Provides load / stall (hold) / bubble (NOP inject), synchronous reset and mispredict status masking.
- Also provides saturating stall/bubble performance counters and a sticky control-conflict flag.

---
 rtl/y86_pkg.sv | 29 ++
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_stage_reg.sv | 123 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 encodings: status codes, instruction codes, register IDs.
package y86_pkg;

  localparam logic [3:0] SAOK = 4'd1;
  localparam logic [3:0] SHLT = 4'd2;
  localparam logic [3:0] SADR = 4'd3;
  localparam logic [3:0] SINS = 4'd4;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  // Faults that a wrong-path instruction may raise and that must not retire.
  function automatic logic is_fault_stat(input logic [3:0] stat);
    return (stat == SHLT) || (stat == SADR) || (stat == SINS);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable Y86 inter-stage pipeline register with load/stall/bubble control,
// wrong-path status masking, stall/bubble counters and a sticky conflict flag.
module pipe_stage_reg
  import y86_pkg::*;
#(
  parameter int unsigned WORD_W             = 64,
  parameter int unsigned REG_W              = 4,
  parameter int unsigned CNT_W              = 16,
  parameter bit          MASK_ON_MISPREDICT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              bubble,
  input  logic              mispredict,
  input  logic [3:0]        in_stat,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [WORD_W-1:0] in_valC,
  input  logic [WORD_W-1:0] in_valA,
  input  logic [WORD_W-1:0] in_valB,
  input  logic [REG_W-1:0]  in_dstE,
  input  logic [REG_W-1:0]  in_dstM,
  input  logic [REG_W-1:0]  in_srcA,
  input  logic [REG_W-1:0]  in_srcB,
  output logic [3:0]        out_stat,
  output logic [3:0]        out_icode,
  output logic [3:0]        out_ifun,
  output logic [WORD_W-1:0] out_valC,
  output logic [WORD_W-1:0] out_valA,
  output logic [WORD_W-1:0] out_valB,
  output logic [REG_W-1:0]  out_dstE,
  output logic [REG_W-1:0]  out_dstM,
  output logic [REG_W-1:0]  out_srcA,
  output logic [REG_W-1:0]  out_srcB,
  output logic              out_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic              ctl_conflict
);

  logic [3:0]        r_stat, r_icode, r_ifun;
  logic [WORD_W-1:0] r_valC, r_valA, r_valB;
  logic [REG_W-1:0]  r_dstE, r_dstM, r_srcA, r_srcB;
  logic              r_valid;
  logic              r_conflict;
  logic [3:0]        w_stat_ld;
  logic              w_stall_inc;

  assign w_stat_ld = (MASK_ON_MISPREDICT && mispredict && is_fault_stat(in_stat)) ? SAOK
                                                                                  : in_stat;
  // A bubble overrides a stall, so a simultaneous request counts only as a bubble.
  assign w_stall_inc = stall && !bubble;

  // Reset and bubble load the same NOP image; only reset also clears the counters.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      r_stat  <= SAOK;
      r_icode <= INOP;
      r_ifun  <= 4'h0;
      r_valC  <= '0;
      r_valA  <= '0;
      r_valB  <= '0;
      r_dstE  <= {REG_W{1'b1}};
      r_dstM  <= {REG_W{1'b1}};
      r_srcA  <= {REG_W{1'b1}};
      r_srcB  <= {REG_W{1'b1}};
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_stat  <= w_stat_ld;
      r_icode <= in_icode;
      r_ifun  <= in_ifun;
      r_valC  <= in_valC;
      r_valA  <= in_valA;
      r_valB  <= in_valB;
      r_dstE  <= in_dstE;
      r_dstM  <= in_dstM;
      r_srcA  <= in_srcA;
      r_srcB  <= in_srcB;
      r_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict <= 1'b0;
    end else if (stall && bubble) begin
      r_conflict <= 1'b1;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble),
    .count (bubble_cnt)
  );

  assign out_stat     = r_stat;
  assign out_icode    = r_icode;
  assign out_ifun     = r_ifun;
  assign out_valC     = r_valC;
  assign out_valA     = r_valA;
  assign out_valB     = r_valB;
  assign out_dstE     = r_dstE;
  assign out_dstM     = r_dstM;
  assign out_srcA     = r_srcA;
  assign out_srcB     = r_srcB;
  assign out_valid    = r_valid;
  assign ctl_conflict = r_conflict;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a default instance and a (no-mask, 3-bit counter) instance
// driven in parallel and checked against a transaction-level stage model.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, bubble, mispredict;
  logic [3:0]  in_stat, in_icode, in_ifun;
  logic [63:0] in_valC, in_valA, in_valB;
  logic [3:0]  in_dstE, in_dstM, in_srcA, in_srcB;

  logic [3:0]  a_stat, a_icode, a_ifun, a_dstE, a_dstM, a_srcA, a_srcB;
  logic [63:0] a_valC, a_valA, a_valB;
  logic        a_valid, a_conf;
  logic [15:0] a_scnt, a_bcnt;

  logic [3:0]  b_stat, b_icode, b_ifun, b_dstE, b_dstM, b_srcA, b_srcB;
  logic [63:0] b_valC, b_valA, b_valB;
  logic        b_valid, b_conf;
  logic [2:0]  b_scnt, b_bcnt;

  pipe_stage_reg dut_a (
    .clk(clk), .rst(rst), .stall(stall), .bubble(bubble), .mispredict(mispredict),
    .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun),
    .in_valC(in_valC), .in_valA(in_valA), .in_valB(in_valB),
    .in_dstE(in_dstE), .in_dstM(in_dstM), .in_srcA(in_srcA), .in_srcB(in_srcB),
    .out_stat(a_stat), .out_icode(a_icode), .out_ifun(a_ifun),
    .out_valC(a_valC), .out_valA(a_valA), .out_valB(a_valB),
    .out_dstE(a_dstE), .out_dstM(a_dstM), .out_srcA(a_srcA), .out_srcB(a_srcB),
    .out_valid(a_valid), .stall_cnt(a_scnt), .bubble_cnt(a_bcnt), .ctl_conflict(a_conf)
  );

  pipe_stage_reg #(
    .CNT_W(3), .MASK_ON_MISPREDICT(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .bubble(bubble), .mispredict(mispredict),
    .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun),
    .in_valC(in_valC), .in_valA(in_valA), .in_valB(in_valB),
    .in_dstE(in_dstE), .in_dstM(in_dstM), .in_srcA(in_srcA), .in_srcB(in_srcB),
    .out_stat(b_stat), .out_icode(b_icode), .out_ifun(b_ifun),
    .out_valC(b_valC), .out_valA(b_valA), .out_valB(b_valB),
    .out_dstE(b_dstE), .out_dstM(b_dstM), .out_srcA(b_srcA), .out_srcB(b_srcB),
    .out_valid(b_valid), .stall_cnt(b_scnt), .bubble_cnt(b_bcnt), .ctl_conflict(b_conf)
  );

  typedef struct {
    logic [3:0]  stat, icode, ifun, dstE, dstM, srcA, srcB;
    logic [63:0] valC, valA, valB;
    bit          valid, conf;
    int unsigned scnt, bcnt;
  } model_t;

  model_t ma, mb;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic model_t nop_image();
    model_t n;
    n.stat = 4'd1; n.icode = 4'd1; n.ifun = 4'd0;
    n.valC = 64'd0; n.valA = 64'd0; n.valB = 64'd0;
    n.dstE = 4'hF; n.dstM = 4'hF; n.srcA = 4'hF; n.srcB = 4'hF;
    n.valid = 1'b0; n.conf = 1'b0; n.scnt = 0; n.bcnt = 0;
    return n;
  endfunction

  // Next stage contents from the rules: rst > bubble > stall > load.
  function automatic model_t next_state(model_t m, bit mask_en, int unsigned cmax);
    model_t n;
    if (rst) return nop_image();
    if (bubble) begin
      n = nop_image();
      n.scnt = m.scnt;
      n.bcnt = (m.bcnt < cmax) ? m.bcnt + 1 : m.bcnt;
      n.conf = m.conf || stall;
      return n;
    end
    n = m;
    if (stall) begin
      n.scnt = (m.scnt < cmax) ? m.scnt + 1 : m.scnt;
      return n;
    end
    n.stat = (mask_en && mispredict && in_stat >= 4'd2 && in_stat <= 4'd4) ? 4'd1 : in_stat;
    n.icode = in_icode; n.ifun = in_ifun;
    n.valC = in_valC; n.valA = in_valA; n.valB = in_valB;
    n.dstE = in_dstE; n.dstM = in_dstM; n.srcA = in_srcA; n.srcB = in_srcB;
    n.valid = 1'b1;
    return n;
  endfunction

  task automatic compare_all();
    check("a_stat", 64'(a_stat), 64'(ma.stat));     check("b_stat", 64'(b_stat), 64'(mb.stat));
    check("a_icode", 64'(a_icode), 64'(ma.icode));  check("b_icode", 64'(b_icode), 64'(mb.icode));
    check("a_ifun", 64'(a_ifun), 64'(ma.ifun));     check("b_ifun", 64'(b_ifun), 64'(mb.ifun));
    check("a_valC", a_valC, ma.valC);               check("b_valC", b_valC, mb.valC);
    check("a_valA", a_valA, ma.valA);               check("b_valA", b_valA, mb.valA);
    check("a_valB", a_valB, ma.valB);               check("b_valB", b_valB, mb.valB);
    check("a_dstE", 64'(a_dstE), 64'(ma.dstE));     check("b_dstE", 64'(b_dstE), 64'(mb.dstE));
    check("a_dstM", 64'(a_dstM), 64'(ma.dstM));     check("b_dstM", 64'(b_dstM), 64'(mb.dstM));
    check("a_srcA", 64'(a_srcA), 64'(ma.srcA));     check("b_srcA", 64'(b_srcA), 64'(mb.srcA));
    check("a_srcB", 64'(a_srcB), 64'(ma.srcB));     check("b_srcB", 64'(b_srcB), 64'(mb.srcB));
    check("a_valid", 64'(a_valid), 64'(ma.valid));  check("b_valid", 64'(b_valid), 64'(mb.valid));
    check("a_conf", 64'(a_conf), 64'(ma.conf));     check("b_conf", 64'(b_conf), 64'(mb.conf));
    check("a_scnt", 64'(a_scnt), 64'(ma.scnt));     check("b_scnt", 64'(b_scnt), 64'(mb.scnt));
    check("a_bcnt", 64'(a_bcnt), 64'(ma.bcnt));     check("b_bcnt", 64'(b_bcnt), 64'(mb.bcnt));
  endtask

  task automatic tick();
    ma = next_state(ma, 1'b1, 16'hFFFF);
    mb = next_state(mb, 1'b0, 7);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic rand_data();
    in_stat  = 4'($urandom_range(0, 7));
    in_icode = 4'($urandom);
    in_ifun  = 4'($urandom);
    in_valC  = {$urandom, $urandom};
    in_valA  = {$urandom, $urandom};
    in_valB  = {$urandom, $urandom};
    in_dstE  = 4'($urandom);
    in_dstM  = 4'($urandom);
    in_srcA  = 4'($urandom);
    in_srcB  = 4'($urandom);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; bubble = 1'b0; mispredict = 1'b0;
    rand_data();
    ma = nop_image();
    mb = nop_image();
    tick();
    check("rst_icode", 64'(a_icode), 64'd1);
    check("rst_dstE", 64'(a_dstE), 64'hF);
    check("rst_valid", 64'(a_valid), 64'd0);

    // Plain D-stage load
    rst = 1'b0;
    rand_data();
    in_stat = 4'd1; in_icode = 4'd6; in_ifun = 4'd0;
    in_valA = 64'd5; in_valB = 64'd7; in_dstE = 4'd3;
    tick();
    check("ld_icode", 64'(a_icode), 64'd6);
    check("ld_valA", a_valA, 64'd5);
    check("ld_dstE", 64'(a_dstE), 64'd3);
    check("ld_valid", 64'(a_valid), 64'd1);

    // Load then hold for three stalled cycles while inputs keep changing
    in_icode = 4'd3; in_valC = 64'h100; in_stat = 4'd1;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      tick();
    end
    check("stall_icode", 64'(a_icode), 64'd3);
    check("stall_valC", a_valC, 64'h100);
    check("stall_cnt3", 64'(a_scnt), 64'd3);

    // Bubble injects a NOP
    stall = 1'b0; bubble = 1'b1; in_icode = 4'd5;
    tick();
    check("bub_icode", 64'(a_icode), 64'd1);
    check("bub_srcB", 64'(a_srcB), 64'hF);
    check("bub_valA", a_valA, 64'd0);
    check("bub_valid", 64'(a_valid), 64'd0);
    check("bub_cnt1", 64'(a_bcnt), 64'd1);

    // Wrong-path fault masking
    bubble = 1'b0; mispredict = 1'b1; in_stat = 4'd4;
    tick();
    check("mask_on", 64'(a_stat), 64'd1);
    check("mask_param_off", 64'(b_stat), 64'd4);
    mispredict = 1'b0;
    tick();
    check("mask_nomisp", 64'(a_stat), 64'd4);

    // Simultaneous stall and bubble
    stall = 1'b1; bubble = 1'b1;
    tick();
    check("conf_set", 64'(a_conf), 64'd1);
    check("conf_bcnt", 64'(a_bcnt), 64'd2);
    check("conf_scnt", 64'(a_scnt), 64'd3);
    stall = 1'b0; bubble = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_data();
      tick();
    end
    check("conf_sticky", 64'(a_conf), 64'd1);
    rst = 1'b1;
    tick();
    check("conf_clr", 64'(a_conf), 64'd0);

    // Counter saturation on the 3-bit instance, then reset mid-stall
    rst = 1'b0; stall = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rand_data();
      tick();
    end
    check("sat_b", 64'(b_scnt), 64'd7);
    check("nosat_a", 64'(a_scnt), 64'd12);
    rst = 1'b1;
    tick();
    check("rst_stall_cnt", 64'(b_scnt), 64'd0);
    check("rst_stall_icode", 64'(b_icode), 64'd1);
    check("rst_stall_valid", 64'(b_valid), 64'd0);

    // Randomized control/data traffic
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 99) < 1);
      stall      = ($urandom_range(0, 99) < 25);
      bubble     = ($urandom_range(0, 99) < 15);
      mispredict = ($urandom_range(0, 99) < 30);
      rand_data();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
